mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the `microcore` memory bus, alongside `rom`. The core issues stores of bytes to a TX data register. Bytes are queued in a small FIFO and shifted out as 8N1 serial frames on `uart_tx`. A status register lets firmware poll FIFO and shifter state; the block also gives the testbench a console output path.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h1000_0000: base of the 16-byte register window; must be 16-byte aligned.
- `CLK_DIV`, default 16: clock cycles per serial bit; legal range ≥ 2.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset (asserted when 0).
- `mem_valid`  in  1: bus request valid.
- `mem_ready`  out  1: transaction complete; one-cycle pulse.
- `mem_addr`  in  32: byte address.
- `mem_wdata`  in  32: write data.
- `mem_wstrb`  in  4: byte strobes; 0 means read.
- `mem_rdata`  out  32: read data; valid while `mem_ready` is 1.
- `uart_tx`  out  1: serial output; idle high.
- `irq`  out  1: TX-done interrupt (see Configuration).

## Operation
- **Address decode.** The block is selected when `mem_addr[31:4] == BASE_ADDR[31:4]`. Otherwise it ignores the bus and keeps `mem_ready` at 0.
- **Register map** (offset = `mem_addr[3:2]`):
  - 0 TXDATA: a write with `mem_wstrb[0]=1` pushes `mem_wdata[7:0]`. A write with `mem_wstrb[0]=0` completes without pushing. Reads return 0.
  - 1 STATUS (read-only): bit0 = FIFO full, bit1 = FIFO empty, bit2 = shifter busy, bits[7:4] = FIFO count saturated at 15. All other bits read 0.
  - 2 CTRL: bit0 = irq enable; reset value 0.
  - 3: reserved; reads 0, writes ignored, completes normally.
- **FIFO.** Circular buffer with `$clog2(FIFO_DEPTH)+1`-bit read and write pointers that wrap modulo 2·`FIFO_DEPTH`. The MSB difference distinguishes full from empty.
- **Shifter state machine:** IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. The head byte is popped into the shift register in the same cycle.
  - START: `uart_tx`=0 for `CLK_DIV` cycles, then DATA.
  - DATA: 8 bits LSB-first, each held `CLK_DIV` cycles, then STOP.
  - STOP: `uart_tx`=1 for `CLK_DIV` cycles. In the last cycle of STOP, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Busy.** Shifter busy = (state ≠ IDLE).

## Timing
- **Reset values:** `mem_ready`=0, `mem_rdata`=0, `uart_tx`=1, `irq`=0, FIFO empty, CTRL=0, state IDLE, bit counter 0, divider counter 0.
- **Reset mid-frame:** the frame is abandoned, `uart_tx` goes high asynchronously, and queued bytes are discarded.
- **Accepted transactions:**
  - The block samples `mem_valid` at a rising edge. `mem_ready` rises at the next edge and is high for exactly one cycle.
  - `mem_rdata` is registered and valid in that same cycle; it returns to 0 afterwards.
  - The block never asserts `mem_ready` in two consecutive cycles. The cycle in which `mem_ready` is high does not sample a new request.
- **Write to TXDATA while full:** the block holds `mem_ready` low (stall) until a pop occurs. It accepts the write in the pop cycle, so count stays at `FIFO_DEPTH`, and asserts `mem_ready` on the following edge.
- **Simultaneous push and pop with the FIFO non-full:** count is unchanged and both operations take effect.
- **STATUS snapshot:** a STATUS read reflects state at the accepting edge.
- **Frame length:** 10·`CLK_DIV` cycles. The first start bit appears on `uart_tx` 2 cycles after the `mem_ready` of a push into an empty FIFO with an idle shifter.

## Configuration
- Macro `MMIO_UART_TX_IRQ_EN`.
- **Defined:**
  - `irq` = CTRL.bit0 AND FIFO empty AND shifter IDLE, registered (one-cycle lag).
  - CTRL is read/write.
- **Undefined:**
  - `irq` is tied to 0.
  - CTRL reads 0 and writes complete without effect.

## Test plan
- **Reset:** assert `rst`=0 for 2 cycles, then release → `uart_tx`=1, `mem_ready`=0, and a STATUS read returns 32'h0000_0002.
- **Single byte:** `CLK_DIV`=4, write 32'h0000_00A5 to TXDATA → `uart_tx` shows 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles (40 cycles total), then stays 1.
- **Back-to-back and full stall:** `FIFO_DEPTH`=8, write 10 bytes 0x00..0x09 with no waits.
  - The 10th write stalls until the first pop.
  - Frames are transmitted contiguously with no idle gap.
  - The serial output decodes to 0x00..0x09 in order.
- **Decode:** access BASE_ADDR+32'h20 → `mem_ready` never asserts (testbench times out after 50 cycles as expected). A read of offset 0 returns 0.
- **IRQ:** with `MMIO_UART_TX_IRQ_EN`, write CTRL=1, push 0x55 → `irq` low while busy and high 1 cycle after STOP ends. Without the macro, `irq` stays 0 and CTRL reads 0.
- **Reset mid-frame:** pull `rst` low during DATA → `uart_tx`=1 immediately. After release, STATUS=0x2 and no further frames are sent.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO and status/ctrl registers.
// Define MMIO_UART_TX_IRQ_EN to enable the read/write CTRL register and the TX-done irq.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wptr, rptr, count;
    logic [1:0]    state;
    logic [DW-1:0] div;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          ctrl, full, empty, last, pop, sel, wr, push_req, accept, push;
    logic [3:0]    cnt_sat;
    logic [31:0]   rd_val;
    logic          unused;

    assign count    = wptr - rptr;
    assign empty    = wptr == rptr;
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign cnt_sat  = int'(count) > 15 ? 4'hF : 4'(count);
    assign last     = div == DW'(CLK_DIV - 1);
    assign pop      = !empty && (state == IDLE || (state == STOP && last));
    assign sel      = mem_valid && !mem_ready && mem_addr[31:4] == BASE_ADDR[31:4];
    assign wr       = |mem_wstrb;
    assign push_req = sel && wr && mem_addr[3:2] == 2'd0 && mem_wstrb[0];
    // a push into a full FIFO stalls unless the shifter frees a slot on the same edge
    assign accept   = sel && !(push_req && full && !pop);
    assign push     = accept && push_req;
    assign rd_val   = mem_addr[3:2] == 2'd1 ? {24'd0, cnt_sat, 1'b0, state != IDLE, empty, full} :
                      mem_addr[3:2] == 2'd2 ? {31'd0, ctrl} : 32'd0;
    assign unused   = ^{mem_addr[1:0], mem_wdata[31:8]};

`ifdef MMIO_UART_TX_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl <= 1'b0;
            irq  <= 1'b0;
        end else begin
            if (accept && wr && mem_addr[3:2] == 2'd2 && mem_wstrb[0]) ctrl <= mem_wdata[0];
            irq <= ctrl && empty && state == IDLE;
        end
    end
`else
    assign ctrl = 1'b0;
    assign irq  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= mem_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            state     <= IDLE;
            div       <= '0;
            bit_cnt   <= 3'd0;
            shreg     <= 8'd0;
            uart_tx   <= 1'b1;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
        end else begin
            mem_ready <= accept;
            mem_rdata <= accept && !wr ? rd_val : 32'd0;
            wptr      <= wptr + (AW+1)'(push);
            rptr      <= rptr + (AW+1)'(pop);
            div       <= (state == IDLE || last) ? '0 : div + 1'b1;
            bit_cnt   <= state == DATA ? bit_cnt + 3'(last) : 3'd0;
            // the line is driven from the registered state, so it trails the FSM by one cycle
            uart_tx   <= state == START ? 1'b0 : state == DATA ? shreg[0] : 1'b1;
            if (pop) shreg <= mem[rptr[AW-1:0]];
            else if (state == DATA && last) shreg <= shreg >> 1;
            state     <= pop ? START : !last ? state :
                         state == START ? DATA :
                         state == DATA ? (bit_cnt == 3'd7 ? STOP : DATA) : IDLE;
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized bench for mmio_uart_tx against a frame-schedule model.
// The model places every accepted byte on a timeline of frame start cycles and derives line/status/irq from it.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int D = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0, rst = 1'b0, mem_valid = 1'b0;
    logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0;
    logic [3:0]  mem_wstrb = 4'd0;
    logic        mem_ready, uart_tx, irq;
    logic [31:0] mem_rdata;

    int checks = 0, errors = 0, cyc = 0;
    int acc [128];
    int st [128];
    logic [7:0] dat [128];
    int n_b = 0;
    int ctrl_edge = 0;
    bit ctrl_val = 1'b0;
    logic [7:0] sent_q [$];
    logic [7:0] rx_q [$];
    int rx_st [$];
    bit rx_on = 1'b0;
    int rx_ph = 0;
    logic [7:0] rx_b = 8'd0;
    logic prev_ready = 1'b0;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .uart_tx(uart_tx), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // model queries, all about the DUT state during cycle k (between edges k and k+1)
    function automatic int fifo_cnt(int k);
        int c = 0;
        for (int i = 0; i < n_b; i++) c += (acc[i] <= k ? 1 : 0) - (st[i] <= k ? 1 : 0);
        return c;
    endfunction

    function automatic int frame_at(int k);
        for (int i = 0; i < n_b; i++) if (st[i] <= k && k < st[i] + 10 * D) return i;
        return -1;
    endfunction

    function automatic logic tx_at(int k);
        int i, b;
        i = frame_at(k);
        if (i < 0) return 1'b1;
        b = (k - st[i]) / D;
        return b == 0 ? 1'b0 : b == 9 ? 1'b1 : dat[i][b-1];
    endfunction

    function automatic logic irq_at(int k);
        return ctrl_val && k >= ctrl_edge && frame_at(k) < 0 && fifo_cnt(k) == 0;
    endfunction

    function automatic logic [31:0] status_at(int k);
        int c;
        c = fifo_cnt(k);
        return {24'd0, c > 15 ? 4'hF : 4'(c), 1'b0, frame_at(k) >= 0, c == 0, c == DEPTH};
    endfunction

    function automatic int req_edge();
        return mem_ready ? cyc + 2 : cyc + 1;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                       input int lim, output logic [31:0] rd, output int a, output bit ok);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wd;
        mem_wstrb = ws;
        ok = 1'b0;
        a  = -1;
        rd = 32'd0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                ok = 1'b1;
                a  = cyc;
                rd = mem_rdata;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
    endtask

    task automatic access(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                          output logic [31:0] rd, output int a);
        int e;
        bit ok;
        e = req_edge();
        bus(addr, wd, ws, 100, rd, a, ok);
        chk("access_ready", 32'(ok), 32'd1);
        chk("access_edge", a, e);
    endtask

    task automatic read_status();
        logic [31:0] rd;
        int a;
        access(BASE + 32'h4, 32'd0, 4'd0, rd, a);
        chk("status", rd, status_at(a - 1));
    endtask

    task automatic push(input logic [7:0] b, input logic [3:0] ws, output int a);
        int e, exp_a;
        logic [31:0] rd;
        bit ok;
        e = req_edge();
        exp_a = e;
        if (fifo_cnt(e - 1) >= DEPTH) begin
            exp_a = 32'h7FFF_FFFF;
            for (int i = 0; i < n_b; i++) if (st[i] >= e && st[i] < exp_a) exp_a = st[i];
        end
        acc[n_b] = exp_a;
        dat[n_b] = b;
        st[n_b]  = exp_a + 1;
        if (n_b > 0 && st[n_b-1] + 10 * D > st[n_b]) st[n_b] = st[n_b-1] + 10 * D;
        n_b++;
        sent_q.push_back(b);
        bus(BASE, ($urandom() & 32'hFFFF_FF00) | 32'(b), ws, 200, rd, a, ok);
        chk("push_ready", 32'(ok), 32'd1);
        chk("push_edge", a, exp_a);
    endtask

    task automatic wait_idle();
        int end_c;
        end_c = n_b > 0 ? st[n_b-1] + 10 * D + 2 : cyc;
        while (cyc < end_c) idle(1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_tx", uart_tx, 1);
            chk("rst_ready", mem_ready, 0);
            chk("rst_irq", irq, 0);
        end else begin
            chk("tx", uart_tx, tx_at(cyc - 1));
            chk("irq", irq, irq_at(cyc - 1));
            chk("ready_pulse", 32'(mem_ready && prev_ready), 32'd0);
        end
        prev_ready = mem_ready;
    end

    // independent line decoder: mid-bit sampling of each frame
    always @(negedge clk) begin
        if (!rst) rx_on = 1'b0;
        else if (!rx_on) begin
            if (uart_tx === 1'b0) begin
                rx_on = 1'b1;
                rx_ph = 0;
                rx_st.push_back(cyc);
            end
        end else begin
            rx_ph++;
            if (rx_ph % D == D / 2 && rx_ph / D >= 1 && rx_ph / D <= 8) rx_b[rx_ph / D - 1] = uart_tx;
            if (rx_ph == 9 * D + D / 2) begin
                chk("rx_stop", uart_tx, 1);
                rx_q.push_back(rx_b);
                rx_on = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int a, a0, a9, n0, r;
        logic [31:0] rd;
        logic [3:0] ws;
        bit ok;
        logic [9:0] pat;
        a0 = 0;
        a9 = 0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        chk("reset_tx", uart_tx, 1);
        chk("reset_ready", mem_ready, 0);
        access(BASE + 32'h4, 32'd0, 4'd0, rd, a);
        chk("reset_status", rd, 32'h0000_0002);

        pat = {1'b1, 8'hA5, 1'b0};
        push(8'hA5, 4'h1, a);
        idle(1);
        chk("a5_pre_start", uart_tx, 1);
        for (int j = 0; j < 10 * D; j++) begin
            idle(1);
            chk("a5_frame", uart_tx, pat[j / D]);
        end
        idle(1);
        chk("a5_after", uart_tx, 1);

        for (int i = 0; i < 10; i++) begin
            push(8'(i), 4'hF, a);
            if (i == 0) a0 = a;
            if (i == 9) a9 = a;
        end
        chk("stall_latency", a9 - a0, 41);
        wait_idle();
        chk("rx_count", rx_q.size(), 11);
        if (rx_q.size() > 0) chk("rx_a5", rx_q[0], 8'hA5);
        for (int i = 0; i < 10 && i + 1 < rx_q.size(); i++) chk("burst_byte", rx_q[i+1], i);
        for (int i = 1; i < 10 && i + 1 < rx_st.size(); i++) chk("burst_gap", rx_st[i+1] - rx_st[i], 40);

        bus(BASE + 32'h20, 32'd0, 4'd0, 50, rd, a, ok);
        chk("decode_miss", 32'(ok), 32'd0);
        access(BASE, 32'd0, 4'd0, rd, a);
        chk("txdata_read", rd, 32'd0);
        access(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, rd, a);
        access(BASE + 32'hC, 32'd0, 4'd0, rd, a);
        chk("reserved_read", rd, 32'd0);

        access(BASE + 32'h8, 32'd1, 4'h1, rd, a);
`ifdef MMIO_UART_TX_IRQ_EN
        ctrl_val = 1'b1;
        ctrl_edge = a;
`endif
        access(BASE + 32'h8, 32'd0, 4'd0, rd, a);
        chk("ctrl_read", rd, 32'(ctrl_val));
        push(8'h55, 4'h1, a);
        while (cyc < a + 41) idle(1);
        chk("irq_in_stop", irq, 0);
        idle(1);
        chk("irq_done", irq, 32'(ctrl_val));

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                ws = 4'h1 | 4'($urandom_range(0, 7) << 1);
                push(8'($urandom()), ws, a);
            end else if (r < 7) read_status();
            else if (r == 7) begin
                ws = 4'($urandom_range(1, 7) << 1);
                access(BASE, $urandom(), ws, rd, a);
            end else if (r == 8) begin
                access(BASE + 32'hC, $urandom(), 4'hF, rd, a);
                access(BASE + 32'hC, 32'd0, 4'd0, rd, a);
                chk("reserved_read", rd, 32'd0);
            end else begin
                access(BASE + 32'h8, 32'd0, 4'd0, rd, a);
                chk("ctrl_read", rd, 32'(ctrl_val));
            end
            idle($urandom_range(0, 3) == 0 ? $urandom_range(0, 60) : 0);
        end
        wait_idle();
        read_status();
        chk("rx_total", rx_q.size(), sent_q.size());
        for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++) chk("rx_byte", rx_q[i], sent_q[i]);

        push(8'h3C, 4'h1, a0);
        push(8'hC3, 4'h1, a);
        push(8'h81, 4'h1, a);
        while (cyc < a0 + 1 + D + 8) idle(1);
        n0 = rx_q.size();
        rst = 1'b0;
        n_b = 0;
        ctrl_val = 1'b0;
        #1;
        chk("reset_mid_tx", uart_tx, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        access(BASE + 32'h4, 32'd0, 4'd0, rd, a);
        chk("reset_mid_status", rd, 32'h0000_0002);
        idle(100);
        chk("no_frames", rx_q.size(), n0);
        chk("tx_idle", uart_tx, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
